// File: rtl/mem_stage_unit_pkg.sv
// Shared types and constants for the MEM pipeline stage: word width,
// link register number and the data-memory handshake state encoding.
package mem_stage_unit_pkg;

   localparam int WORD_WIDTH = 32;
   localparam logic [4:0] LINK_REGISTER = 5'd31;

   typedef logic [WORD_WIDTH-1:0] word_t;

   typedef enum logic {
      STATE_IDLE,
      STATE_WAIT
   } mem_state_t;

endpackage

// File: rtl/mem_stage_unit_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// data memory (slave).
interface mem_stage_unit_if;
   import mem_stage_unit_pkg::*;

   logic  req;
   logic  we;
   word_t addr;
   word_t wdata;
   logic  ready;
   word_t rdata;

   modport master (
      output req,
      output we,
      output addr,
      output wdata,
      input  ready,
      input  rdata
   );

   modport slave (
      input  req,
      input  we,
      input  addr,
      input  wdata,
      output ready,
      output rdata
   );

endinterface

// File: rtl/mem_redirect_resolve.sv
// Combinational control-transfer resolution: decides whether the instruction
// in MEM redirects fetch and where to, with JR > J/JAL > taken branch.
module mem_redirect_resolve
   import mem_stage_unit_pkg::*;
(
   input  word_t       pc_4,
   input  logic [25:0] jump_index,
   input  logic        is_jump,
   input  logic        is_jump_and_link,
   input  logic        is_jump_register,
   input  logic        is_branch,
   input  logic        is_bne_else_beq,
   input  word_t       alu_zero_flag,
   input  word_t       alu_output,
   input  word_t       branch_pc,
   output logic        transfer,
   output word_t       target
);

   logic branch_taken;

   // A nonzero flag word means the ALU result was zero (equal operands).
   always_comb begin
      branch_taken = is_branch & (is_bne_else_beq ? (alu_zero_flag == '0)
                                                  : (alu_zero_flag != '0));
      transfer     = 1'b0;
      target       = '0;
      if (is_jump_register) begin
         transfer = 1'b1;
         target   = alu_output;
      end else if (is_jump | is_jump_and_link) begin
         transfer = 1'b1;
         target   = {pc_4[31:28], jump_index, 2'b00};
      end else if (branch_taken) begin
         transfer = 1'b1;
         target   = branch_pc;
      end
   end

endmodule

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: data-memory access with ready/stall handshake,
// fetch redirect for jumps/branches and the registered writeback bundle.
module mem_stage_unit
   import mem_stage_unit_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  word_t                   mem_pc_4,
   input  word_t                   mem_instruction,
   input  logic                    mem_isJump,
   input  logic                    mem_isJumpAndLink,
   input  logic                    mem_isJumpRegister,
   input  logic [25:0]             mem_jumpIndex,
   input  logic                    mem_isBranch,
   input  logic                    mem_isBneElseBeq,
   input  word_t                   mem_isAluOutputZero,
   input  word_t                   mem_branchPc,
   input  word_t                   mem_aluOutput,
   input  word_t                   mem_registerRt,
   input  logic                    mem_shouldWriteRegister,
   input  logic [4:0]              mem_registerWriteAddress,
   input  logic                    mem_shouldWriteMemoryElseAluOutputToRegister,
   input  logic                    mem_shouldWriteMemory,
   mem_stage_unit_if.master        dmem,
   output logic                    redirect_valid,
   output word_t                   redirect_pc,
   output logic                    stall,
   output logic                    wb_writeEnable,
   output logic [4:0]              wb_writeAddress,
   output word_t                   wb_writeData
);

   mem_state_t state;
   mem_state_t state_next;

   logic  is_load;
   logic  is_store;
   logic  is_access;
   logic  held_we;
   word_t held_addr;
   word_t held_wdata;
   logic  transfer;
   word_t transfer_target;
   logic  [4:0] wb_address_next;
   logic  wb_enable_next;
   word_t wb_data_next;
   logic  unused_instruction;

   // The instruction word travels with the stage for tracing only.
   assign unused_instruction = ^mem_instruction;

   assign is_load   = mem_shouldWriteMemoryElseAluOutputToRegister & mem_shouldWriteRegister;
   assign is_store  = mem_shouldWriteMemory;
   assign is_access = is_load | is_store;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= STATE_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         STATE_IDLE: if (is_access && !dmem.ready) state_next = STATE_WAIT;
         STATE_WAIT: if (dmem.ready) state_next = STATE_IDLE;
         default:    state_next = STATE_IDLE;
      endcase
   end

   // Reset overrides the bus so a late dmem_ready cannot complete anything.
   always_comb begin
      dmem.req   = 1'b0;
      dmem.we    = 1'b0;
      dmem.addr  = '0;
      dmem.wdata = '0;
      stall      = 1'b0;
      if (!reset) begin
         case (state)
            STATE_IDLE: begin
               if (is_access) begin
                  dmem.req   = 1'b1;
                  dmem.we    = is_store;
                  dmem.addr  = mem_aluOutput;
                  dmem.wdata = mem_registerRt;
                  stall      = !dmem.ready;
               end
            end
            STATE_WAIT: begin
               dmem.req   = 1'b1;
               dmem.we    = held_we;
               dmem.addr  = held_addr;
               dmem.wdata = held_wdata;
               stall      = !dmem.ready;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         held_we    <= 1'b0;
         held_addr  <= '0;
         held_wdata <= '0;
      end else if (state == STATE_IDLE && is_access && !dmem.ready) begin
         held_we    <= is_store;
         held_addr  <= mem_aluOutput;
         held_wdata <= mem_registerRt;
      end
   end

   mem_redirect_resolve u_redirect (
      .pc_4             (mem_pc_4),
      .jump_index       (mem_jumpIndex),
      .is_jump          (mem_isJump),
      .is_jump_and_link (mem_isJumpAndLink),
      .is_jump_register (mem_isJumpRegister),
      .is_branch        (mem_isBranch),
      .is_bne_else_beq  (mem_isBneElseBeq),
      .alu_zero_flag    (mem_isAluOutputZero),
      .alu_output       (mem_aluOutput),
      .branch_pc        (mem_branchPc),
      .transfer         (transfer),
      .target           (transfer_target)
   );

   assign redirect_valid = !reset && transfer && !stall;
   assign redirect_pc    = reset ? '0 : transfer_target;

   assign wb_address_next = mem_isJumpAndLink ? LINK_REGISTER : mem_registerWriteAddress;
   assign wb_enable_next  = (mem_shouldWriteRegister | mem_isJumpAndLink) & !is_store
                            & (wb_address_next != 5'd0);
   assign wb_data_next    = is_load           ? dmem.rdata :
                            mem_isJumpAndLink ? mem_pc_4   : mem_aluOutput;

   // Stalled cycles push a bubble; address/data keep their last values.
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_writeEnable  <= 1'b0;
         wb_writeAddress <= '0;
         wb_writeData    <= '0;
      end else if (stall) begin
         wb_writeEnable  <= 1'b0;
      end else begin
         wb_writeEnable  <= wb_enable_next;
         wb_writeAddress <= wb_address_next;
         wb_writeData    <= wb_data_next;
      end
   end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: directed vectors with literal
// expectations plus a per-cycle reference model of the stage behaviour.
module tb_mem_stage_unit;

   typedef struct packed {
      logic        is_jump;
      logic        is_jal;
      logic        is_jr;
      logic        is_branch;
      logic        is_bne;
      logic [31:0] zero_flag;
      logic [31:0] branch_pc;
      logic [31:0] alu;
      logic [31:0] rt;
      logic [31:0] pc_4;
      logic [25:0] jump_index;
      logic        swr;
      logic [4:0]  rd;
      logic        load_sel;
      logic        store;
      logic        ready;
      logic [31:0] rdata;
   } stim_t;

   logic        clock;
   logic        reset;
   logic [31:0] mem_pc_4;
   logic [31:0] mem_instruction;
   logic        mem_isJump;
   logic        mem_isJumpAndLink;
   logic        mem_isJumpRegister;
   logic [25:0] mem_jumpIndex;
   logic        mem_isBranch;
   logic        mem_isBneElseBeq;
   logic [31:0] mem_isAluOutputZero;
   logic [31:0] mem_branchPc;
   logic [31:0] mem_aluOutput;
   logic [31:0] mem_registerRt;
   logic        mem_shouldWriteRegister;
   logic [4:0]  mem_registerWriteAddress;
   logic        mem_shouldWriteMemoryElseAluOutputToRegister;
   logic        mem_shouldWriteMemory;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        wb_writeEnable;
   logic [4:0]  wb_writeAddress;
   logic [31:0] wb_writeData;

   int check_count = 0;
   int error_count = 0;
   logic check_enable = 1'b0;

   mem_stage_unit_if dmem_bus ();

   mem_stage_unit dut (
      .clock                                        (clock),
      .reset                                        (reset),
      .mem_pc_4                                     (mem_pc_4),
      .mem_instruction                              (mem_instruction),
      .mem_isJump                                   (mem_isJump),
      .mem_isJumpAndLink                            (mem_isJumpAndLink),
      .mem_isJumpRegister                           (mem_isJumpRegister),
      .mem_jumpIndex                                (mem_jumpIndex),
      .mem_isBranch                                 (mem_isBranch),
      .mem_isBneElseBeq                             (mem_isBneElseBeq),
      .mem_isAluOutputZero                          (mem_isAluOutputZero),
      .mem_branchPc                                 (mem_branchPc),
      .mem_aluOutput                                (mem_aluOutput),
      .mem_registerRt                               (mem_registerRt),
      .mem_shouldWriteRegister                      (mem_shouldWriteRegister),
      .mem_registerWriteAddress                     (mem_registerWriteAddress),
      .mem_shouldWriteMemoryElseAluOutputToRegister (mem_shouldWriteMemoryElseAluOutputToRegister),
      .mem_shouldWriteMemory                        (mem_shouldWriteMemory),
      .dmem                                         (dmem_bus.master),
      .redirect_valid                               (redirect_valid),
      .redirect_pc                                  (redirect_pc),
      .stall                                        (stall),
      .wb_writeEnable                               (wb_writeEnable),
      .wb_writeAddress                              (wb_writeAddress),
      .wb_writeData                                 (wb_writeData)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic driveInputs(input stim_t s, input logic rst);
      reset                                        = rst;
      mem_isJump                                   = s.is_jump;
      mem_isJumpAndLink                            = s.is_jal;
      mem_isJumpRegister                           = s.is_jr;
      mem_isBranch                                 = s.is_branch;
      mem_isBneElseBeq                             = s.is_bne;
      mem_isAluOutputZero                          = s.zero_flag;
      mem_branchPc                                 = s.branch_pc;
      mem_aluOutput                                = s.alu;
      mem_registerRt                               = s.rt;
      mem_pc_4                                     = s.pc_4;
      mem_jumpIndex                                = s.jump_index;
      mem_shouldWriteRegister                      = s.swr;
      mem_registerWriteAddress                     = s.rd;
      mem_shouldWriteMemoryElseAluOutputToRegister = s.load_sel;
      mem_shouldWriteMemory                        = s.store;
      mem_instruction                              = 32'h0;
      dmem_bus.ready                               = s.ready;
      dmem_bus.rdata                               = s.rdata;
   endtask

   task automatic applyStimulus(input stim_t s, input logic rst);
      @(posedge clock);
      #1;
      driveInputs(s, rst);
   endtask

   // Reference model: one outstanding memory transaction at most, and a
   // writeback bundle that is what the previous unstalled cycle retired.
   logic        model_outstanding = 1'b0;
   logic        model_out_we      = 1'b0;
   logic [31:0] model_out_addr    = '0;
   logic [31:0] model_out_wdata   = '0;
   logic        exp_wb_en         = 1'b0;
   logic [4:0]  exp_wb_addr       = '0;
   logic [31:0] exp_wb_data       = '0;
   logic        exp_req, exp_we, exp_stall, exp_rv, is_ld, is_st, alu_zero, taken;
   logic [31:0] exp_addr, exp_wdata, exp_rpc;
   logic [4:0]  dest;

   always @(negedge clock) begin
      if (check_enable) begin
         checkOutput("model_wb_en",   {31'b0, wb_writeEnable}, {31'b0, exp_wb_en});
         checkOutput("model_wb_addr", {27'b0, wb_writeAddress}, {27'b0, exp_wb_addr});
         checkOutput("model_wb_data", wb_writeData, exp_wb_data);

         is_ld    = mem_shouldWriteMemoryElseAluOutputToRegister && mem_shouldWriteRegister;
         is_st    = mem_shouldWriteMemory;
         alu_zero = (mem_isAluOutputZero != 32'h0);
         taken    = mem_isBranch && (mem_isBneElseBeq ? !alu_zero : alu_zero);
         exp_req = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_stall = 1'b0;
         exp_rv  = 1'b0; exp_rpc = '0;
         if (!reset) begin
            if (model_outstanding) begin
               exp_req = 1'b1; exp_we = model_out_we;
               exp_addr = model_out_addr; exp_wdata = model_out_wdata;
            end else if (is_ld || is_st) begin
               exp_req = 1'b1; exp_we = is_st;
               exp_addr = mem_aluOutput; exp_wdata = mem_registerRt;
            end
            exp_stall = exp_req && !dmem_bus.ready;
            if (mem_isJumpRegister)                     exp_rpc = mem_aluOutput;
            else if (mem_isJump || mem_isJumpAndLink)   exp_rpc = {mem_pc_4[31:28], mem_jumpIndex, 2'b00};
            else if (taken)                             exp_rpc = mem_branchPc;
            exp_rv = (mem_isJumpRegister || mem_isJump || mem_isJumpAndLink || taken) && !exp_stall;
         end
         checkOutput("model_req",   {31'b0, dmem_bus.req}, {31'b0, exp_req});
         checkOutput("model_we",    {31'b0, dmem_bus.we},  {31'b0, exp_we});
         checkOutput("model_addr",  dmem_bus.addr, exp_addr);
         checkOutput("model_wdata", dmem_bus.wdata, exp_wdata);
         checkOutput("model_stall", {31'b0, stall}, {31'b0, exp_stall});
         checkOutput("model_redirect_valid", {31'b0, redirect_valid}, {31'b0, exp_rv});
         checkOutput("model_redirect_pc", redirect_pc, exp_rpc);

         if (reset) begin
            model_outstanding = 1'b0;
            exp_wb_en = 1'b0; exp_wb_addr = '0; exp_wb_data = '0;
         end else if (exp_stall) begin
            if (!model_outstanding) begin
               model_out_we = exp_we; model_out_addr = exp_addr; model_out_wdata = exp_wdata;
            end
            model_outstanding = 1'b1;
            exp_wb_en = 1'b0;
         end else begin
            model_outstanding = 1'b0;
            dest        = mem_isJumpAndLink ? 5'd31 : mem_registerWriteAddress;
            exp_wb_en   = (mem_shouldWriteRegister || mem_isJumpAndLink) && !is_st && (dest != 5'd0);
            exp_wb_addr = dest;
            exp_wb_data = is_ld ? dmem_bus.rdata : (mem_isJumpAndLink ? mem_pc_4 : mem_aluOutput);
         end
      end
   end

   stim_t s;
   int    stall_cycles;

   initial begin
      s = '0;
      driveInputs(s, 1'b1);
      @(posedge clock);
      #1;
      check_enable = 1'b1;
      @(negedge clock);
      checkOutput("reset_stall",    {31'b0, stall}, 32'h0);
      checkOutput("reset_req",      {31'b0, dmem_bus.req}, 32'h0);
      checkOutput("reset_wb_en",    {31'b0, wb_writeEnable}, 32'h0);
      checkOutput("reset_wb_data",  wb_writeData, 32'h0);
      checkOutput("reset_redirect", redirect_pc, 32'h0);
      applyStimulus('0, 1'b0);

      // Store of 10 to 0x40 with memory always ready.
      s = '0; s.store = 1'b1; s.alu = 32'h40; s.rt = 32'd10; s.ready = 1'b1;
      applyStimulus(s, 1'b0);
      @(negedge clock);
      checkOutput("store_req",   {31'b0, dmem_bus.req}, 32'h1);
      checkOutput("store_we",    {31'b0, dmem_bus.we}, 32'h1);
      checkOutput("store_addr",  dmem_bus.addr, 32'h40);
      checkOutput("store_wdata", dmem_bus.wdata, 32'd10);
      checkOutput("store_stall", {31'b0, stall}, 32'h0);
      applyStimulus('0, 1'b0);
      @(negedge clock);
      checkOutput("store_wb_en", {31'b0, wb_writeEnable}, 32'h0);
      checkOutput("store_req_drop", {31'b0, dmem_bus.req}, 32'h0);

      // Load from 0x80 into r5, memory answers on the fourth cycle.
      s = '0; s.load_sel = 1'b1; s.swr = 1'b1; s.rd = 5'd5; s.alu = 32'h80;
      stall_cycles = 0;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(s, 1'b0);
         @(negedge clock);
         if (stall) stall_cycles++;
      end
      s.ready = 1'b1; s.rdata = 32'hDEADBEEF;
      applyStimulus(s, 1'b0);
      @(negedge clock);
      checkOutput("load_stall_cycles", stall_cycles, 32'd3);
      checkOutput("load_done_stall", {31'b0, stall}, 32'h0);
      checkOutput("load_we", {31'b0, dmem_bus.we}, 32'h0);
      applyStimulus('0, 1'b0);
      @(negedge clock);
      checkOutput("load_wb_en",   {31'b0, wb_writeEnable}, 32'h1);
      checkOutput("load_wb_addr", {27'b0, wb_writeAddress}, 32'd5);
      checkOutput("load_wb_data", wb_writeData, 32'hDEADBEEF);

      // BEQ taken, then BNE with the same flags not taken.
      s = '0; s.is_branch = 1'b1; s.zero_flag = 32'h1; s.branch_pc = 32'h100;
      applyStimulus(s, 1'b0);
      @(negedge clock);
      checkOutput("beq_valid", {31'b0, redirect_valid}, 32'h1);
      checkOutput("beq_pc",    redirect_pc, 32'h100);
      s.is_bne = 1'b1;
      applyStimulus(s, 1'b0);
      @(negedge clock);
      checkOutput("bne_valid", {31'b0, redirect_valid}, 32'h0);

      // JAL links to r31 and jumps into the current 256 MB region.
      s = '0; s.is_jal = 1'b1; s.pc_4 = 32'h00400008; s.jump_index = 26'h0000010;
      applyStimulus(s, 1'b0);
      @(negedge clock);
      checkOutput("jal_valid", {31'b0, redirect_valid}, 32'h1);
      checkOutput("jal_pc",    redirect_pc, 32'h00000040);
      applyStimulus('0, 1'b0);
      @(negedge clock);
      checkOutput("jal_wb_en",   {31'b0, wb_writeEnable}, 32'h1);
      checkOutput("jal_wb_addr", {27'b0, wb_writeAddress}, 32'd31);
      checkOutput("jal_wb_data", wb_writeData, 32'h00400008);

      s = '0; s.is_jr = 1'b1; s.alu = 32'h00001234;
      applyStimulus(s, 1'b0);
      @(negedge clock);
      checkOutput("jr_pc", redirect_pc, 32'h00001234);

      // ALU writes to r0 are dropped, to r7 retire normally.
      s = '0; s.swr = 1'b1; s.rd = 5'd0; s.alu = 32'h77;
      applyStimulus(s, 1'b0);
      s.rd = 5'd7;
      applyStimulus(s, 1'b0);
      @(negedge clock);
      checkOutput("alu_r0_wb_en", {31'b0, wb_writeEnable}, 32'h0);
      applyStimulus('0, 1'b0);
      @(negedge clock);
      checkOutput("alu_r7_wb_en",   {31'b0, wb_writeEnable}, 32'h1);
      checkOutput("alu_r7_wb_data", wb_writeData, 32'h77);

      // Waiting store keeps its captured address/data even if inputs move.
      s = '0; s.store = 1'b1; s.alu = 32'h200; s.rt = 32'hAB;
      applyStimulus(s, 1'b0);
      s.alu = 32'h999; s.rt = 32'h0;
      applyStimulus(s, 1'b0);
      @(negedge clock);
      checkOutput("held_addr",  dmem_bus.addr, 32'h200);
      checkOutput("held_wdata", dmem_bus.wdata, 32'hAB);
      checkOutput("held_stall", {31'b0, stall}, 32'h1);
      s.ready = 1'b1;
      applyStimulus(s, 1'b0);
      @(negedge clock);
      checkOutput("held_done_stall", {31'b0, stall}, 32'h0);

      // Reset while a load waits; ready during and after reset is ignored.
      s = '0; s.load_sel = 1'b1; s.swr = 1'b1; s.rd = 5'd9; s.alu = 32'h300;
      applyStimulus(s, 1'b0);
      applyStimulus(s, 1'b0);
      s.ready = 1'b1; s.rdata = 32'h1111;
      applyStimulus(s, 1'b1);
      @(negedge clock);
      checkOutput("rst_wait_stall", {31'b0, stall}, 32'h0);
      checkOutput("rst_wait_req",   {31'b0, dmem_bus.req}, 32'h0);
      s = '0; s.ready = 1'b1;
      applyStimulus(s, 1'b0);
      @(negedge clock);
      checkOutput("rst_after_req",   {31'b0, dmem_bus.req}, 32'h0);
      checkOutput("rst_after_wb_en", {31'b0, wb_writeEnable}, 32'h0);
      applyStimulus('0, 1'b0);
      @(negedge clock);
      checkOutput("rst_after_wb_en2", {31'b0, wb_writeEnable}, 32'h0);

      applyStimulus('0, 1'b0);
      @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/mem_stage_unit.md
MEM_STAGE_UNIT -- requirements
Module: mem_stage_unit

Interface
REQ-001 clock  in  1  single system clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 mem_pc_4, mem_instruction  in  32 each  PC+4 and instruction word from the EX/MEM register.
REQ-004 mem_isJump, mem_isJumpAndLink, mem_isJumpRegister  in  1 each  jump class flags; mem_jumpIndex  in  26  J-type index.
REQ-005 mem_isBranch, mem_isBneElseBeq  in  1 each; mem_isAluOutputZero  in  32 (nonzero = ALU zero); mem_branchPc  in  32  branch target.
REQ-006 mem_aluOutput  in  32  ALU result, data address or JR target; mem_registerRt  in  32  store data.
REQ-007 mem_shouldWriteRegister  in  1; mem_registerWriteAddress  in  5; mem_shouldWriteMemoryElseAluOutputToRegister  in  1 (load select); mem_shouldWriteMemory  in  1 (store).
REQ-008 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32; dmem_ready  in  1; dmem_rdata  in  32.
REQ-009 redirect_valid  out  1; redirect_pc  out  32; stall  out  1 (freeze IF..EX/MEM); wb_writeEnable  out  1; wb_writeAddress  out  5; wb_writeData  out  32.

Function
REQ-010 Access = load (load select and shouldWriteRegister) or store (shouldWriteMemory); otherwise the instruction is pass-through.
REQ-011 FSM states IDLE, WAIT; IDLE with access -> drive dmem_req=1, dmem_we=store, dmem_addr=mem_aluOutput, dmem_wdata=mem_registerRt combinationally; if dmem_ready same cycle, complete and stay IDLE, else go WAIT.
REQ-012 In WAIT, dmem_req and address/data/we are held from registered copies; stall=1; transition to IDLE on the first cycle dmem_ready=1 (completion cycle stall=0).
REQ-013 stall = access pending and not dmem_ready, in both states; pass-through instructions never stall.
REQ-014 Load completion: register dmem_rdata into wb_writeData; non-load: wb_writeData = mem_aluOutput, except JAL: wb_writeData = mem_pc_4, wb_writeAddress = 31.
REQ-015 wb_* are registered (one-cycle latency) and update only on a non-stalled cycle; stalled cycles write wb_writeEnable=0 (bubble).
REQ-016 wb_writeEnable = mem_shouldWriteRegister or JAL, forced 0 if write address is 0.
REQ-017 Branch taken = mem_isBranch and (mem_isBneElseBeq ? isAluOutputZero==0 : isAluOutputZero!=0).
REQ-018 redirect_pc priority: JR -> mem_aluOutput; J/JAL -> {mem_pc_4[31:28], mem_jumpIndex, 2'b00}; taken branch -> mem_branchPc.
REQ-019 redirect_valid combinational, asserted for exactly one cycle per control-transfer instruction, only on its non-stalled cycle.
REQ-020 Store never sets wb_writeEnable; dmem_we=0 for loads.

Reset
REQ-021 On reset: FSM IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, stall=0, redirect_valid=0, redirect_pc=0, wb_writeEnable=0, wb_writeAddress=0, wb_writeData=0.
REQ-022 Reset mid-WAIT abandons the access; dmem_ready arriving in the reset cycle or after is ignored until a new request.

Structure
REQ-023 Shared package holds the FSM state enum, JAL link register constant (31), and the 32-bit word width.
REQ-024 One natural sub-module: mem_redirect_resolve (combinational branch/jump target and taken logic).

Verification
REQ-025 Store x10 to addr 0x40, dmem_ready tied 1 -> one-cycle dmem_req/we=1, stall never high, wb_writeEnable=0.
REQ-026 Load addr 0x80, dmem_ready after 3 cycles, rdata 0xDEADBEEF, rd=5 -> stall high 3 cycles, next cycle wb: en=1, addr=5, data 0xDEADBEEF.
REQ-027 BEQ with isAluOutputZero=1, branchPc=0x100 -> redirect_valid=1, redirect_pc=0x100; BNE same inputs -> redirect_valid=0.
REQ-028 JAL pc_4=0x00400008, index=0x0000010 -> redirect_pc=0x00000040, wb addr 31, data 0x00400008.
REQ-029 Reset asserted in WAIT, then dmem_ready=1 -> stall=0, dmem_req=0, no wb write.
REQ-030 ALU op writing rd=0 -> wb_writeEnable=0.
